// File: rtl/mux16_2_arb.sv
// mux16_2_arb: merges two valid/ready source channels onto one registered
// destination channel.
// Build option: define MUX16_2_ROUND_ROBIN_EN to arbitrate round-robin. Left
// undefined, in0 has fixed priority and in1 can be starved by a busy in0.
// The output stage is a single register slot. It can drain and reload on the
// same edge, so it sustains one transfer per cycle.
module mux16_2_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
);

  // Per-channel views, so the counter and ready logic can be generated.
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [1:0] in_xfer;

  assign in_valid = {in1_valid, in0_valid};

  // Arbitration and output-stage signals.
  logic             load_ok;
  logic             win_valid;
  logic             win_sel;
  logic [WIDTH-1:0] win_data;
  logic             xfer;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_src_q,   out_src_d;

`ifdef MUX16_2_ROUND_ROBIN_EN
  // Remembers the channel granted last. Resets to 1 so in0 wins the first contest.
  logic last_grant_q, last_grant_d;
`endif

  // The slot can take new data when it is empty or is draining this cycle.
  // This is the only combinational path from out_ready to the input readies.
  // Holding the readies low during reset keeps producers from handing off
  // data that would be lost.
  assign load_ok = rst_n && (!out_valid_q || out_ready);

  // Winner selection. Only a channel that is currently valid can be chosen.
  always_comb begin
    win_valid = in0_valid || in1_valid;
    win_sel   = 1'b0;
`ifdef MUX16_2_ROUND_ROBIN_EN
    if (in0_valid && in1_valid) begin
      win_sel = ~last_grant_q;
    end else begin
      win_sel = in1_valid;
    end
`else
    win_sel = !in0_valid && in1_valid;
`endif
  end

  assign win_data = win_sel ? in1_data : in0_data;
  assign xfer     = load_ok && win_valid;

  // Readies and grant counters are built the same way for each channel.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [15:0] cnt_q, cnt_d;

    // The readies are one-hot. A channel's ready depends on its own valid
    // only through the winner selection.
    assign in_ready[gi] = load_ok && win_valid &&
                          ((gi == 1) ? win_sel : !win_sel);
    assign in_xfer[gi]  = in_ready[gi] && in_valid[gi];

    // Counts accepted transfers. The counter wraps naturally at 2^16.
    always_comb begin
      cnt_d = cnt_q;
      if (in_xfer[gi]) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    // Grant counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign in0_ready  = in_ready[0];
  assign in1_ready  = in_ready[1];
  assign grant_cnt0 = g_chan[0].cnt_q;
  assign grant_cnt1 = g_chan[1].cnt_q;

  // Output slot next state. A load has precedence over a drain. When both
  // happen on one edge, the slot stays valid and takes the new data.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_src_d   = win_sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot register. A reset discards any data it is holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

`ifdef MUX16_2_ROUND_ROBIN_EN
  // Round-robin pointer. It moves only when a transfer actually happens.
  always_comb begin
    last_grant_d = last_grant_q;
    if (xfer) begin
      last_grant_d = win_sel;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux16_2_arb.sv
// Directed testbench for mux16_2_arb. Expected values are worked out by hand
// for the round-robin build or the fixed-priority build, whichever is compiled.
module tb_mux16_2_arb;

`ifdef MUX16_2_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in0_valid = 1'b0;
  logic        in0_ready;
  logic [15:0] in0_data = '0;
  logic        in1_valid = 1'b0;
  logic        in1_ready;
  logic [15:0] in1_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_src;
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  mux16_2_arb #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .in0_data   (in0_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in1_data   (in1_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse the reset low between clock edges and clear all inputs.
  task automatic do_reset();
    tick();
    rst_n     = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_d;
    logic        exp_s;

    // Test 1: reset state, then the first transfer after reset release.
    in0_valid = 1'b1;
    in0_data  = 16'h1234;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    check("rst_in0_ready", in0_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_src", out_src, 0);
    check("rst_cnt0", grant_cnt0, 0);
    check("rst_cnt1", grant_cnt1, 0);
    rst_n = 1'b1;
    #1;
    check("t1_in0_ready", in0_ready, 1);
    check("t1_in1_ready", in1_ready, 0);
    tick();
    in0_valid = 1'b0;
    $display("[TB] t1 xfer src=%0d data=%h", out_src, out_data);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 16'h1234);
    check("t1_out_src", out_src, 0);
    check("t1_cnt0", grant_cnt0, 1);
    tick();
    check("t1_drain", out_valid, 0);

    // Test 2: both channels valid and the output always ready.
    do_reset();
    in0_valid = 1'b1;
    in0_data  = 16'hAAAA;
    in1_valid = 1'b1;
    in1_data  = 16'h5555;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_s = RR ? i[0] : 1'b0;
      #1;
      check("t2_in0_ready", in0_ready, !exp_s);
      check("t2_in1_ready", in1_ready, exp_s);
      tick();
      $display("[TB] t2 xfer %0d src=%0d data=%h", i, out_src, out_data);
      check("t2_out_src", out_src, exp_s);
      check("t2_out_data", out_data, exp_s ? 16'h5555 : 16'hAAAA);
      check("t2_out_valid", out_valid, 1);
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    check("t2_cnt0", grant_cnt0, RR ? 3 : 6);
    check("t2_cnt1", grant_cnt1, RR ? 3 : 0);

    // Test 3: the slot holds 0xBEEF through a stall, then drains and reloads on one edge.
    do_reset();
    in0_valid = 1'b1;
    in0_data  = 16'hBEEF;
    tick();
    in0_data  = 16'h1111;
    in1_valid = 1'b1;
    in1_data  = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_in0_ready", in0_ready, 0);
      check("t3_in1_ready", in1_ready, 0);
      tick();
      check("t3_out_data", out_data, 16'hBEEF);
      check("t3_out_valid", out_valid, 1);
      check("t3_out_src", out_src, 0);
      check("t3_cnt0", grant_cnt0, 1);
      check("t3_cnt1", grant_cnt1, 0);
    end
    out_ready = 1'b1;
    #1;
    check("t3_rel_in1_ready", in1_ready, RR ? 1 : 0);
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    $display("[TB] t3 xfer src=%0d data=%h", out_src, out_data);
    check("t3_rel_valid", out_valid, 1);
    check("t3_rel_data", out_data, RR ? 16'h2222 : 16'h1111);
    check("t3_rel_src", out_src, RR ? 1 : 0);

    // Test 4: only in1 valid, with back-to-back incrementing payloads.
    do_reset();
    in1_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_d    = 16'(i + 1);
      in1_data = exp_d;
      tick();
      $display("[TB] t4 xfer %0d src=%0d data=%h", i, out_src, out_data);
      check("t4_out_data", out_data, exp_d);
      check("t4_out_src", out_src, 1);
      check("t4_out_valid", out_valid, 1);
    end
    in1_valid = 1'b0;
    check("t4_cnt1", grant_cnt1, 5);

    // Test 5: the channel-0 grant counter wraps from 0xFFFF to 0.
    do_reset();
    in0_valid = 1'b1;
    in0_data  = 16'h0F0F;
    out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("t5_cnt0_ffff", grant_cnt0, 16'hFFFF);
    tick();
    check("t5_cnt0_wrap", grant_cnt0, 16'h0000);
    check("t5_out_valid", out_valid, 1);

    // Test 6: an asynchronous reset mid-cycle discards the held data, and in0 wins afterwards.
    in0_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", out_data, 16'h0000);
    check("t6_cnt0", grant_cnt0, 0);
    in0_valid = 1'b1;
    in0_data  = 16'hC0DE;
    in1_valid = 1'b1;
    in1_data  = 16'hD00D;
    out_ready = 1'b1;
    #1;
    check("t6_rst_ready", in0_ready, 0);
    rst_n = 1'b1;
    #1;
    check("t6_in0_ready", in0_ready, 1);
    check("t6_in1_ready", in1_ready, 0);
    tick();
    $display("[TB] t6 xfer src=%0d data=%h", out_src, out_data);
    check("t6_first_src", out_src, 0);
    check("t6_first_data", out_data, 16'hC0DE);
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    $display("[TB] t6 xfer src=%0d data=%h", out_src, out_data);
    check("t6_second_src", out_src, RR ? 1 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux16_2_arb.md
Name: mux16_2_arb

Overview:
- 2-to-1 merge of two 16-bit source channels onto one destination bus; the converging counterpart to DeMux16_2's splitting.
- Valid/ready handshake on all channels, registered single-entry output stage and round-robin arbitration.
- Sits where two producers share one consumer, e.g. two write-back sources feeding the register-file write port.

Parameters:
- WIDTH, 16, data width of every channel.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in0_valid  input  1  channel 0 has data.
- in0_ready  output  1  channel 0 transfer accepted this cycle.
- in0_data  input  WIDTH  channel 0 payload.
- in1_valid  input  1  channel 1 has data.
- in1_ready  output  1  channel 1 transfer accepted this cycle.
- in1_data  input  WIDTH  channel 1 payload.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts output.
- out_data  output  WIDTH  registered payload.
- out_src  output  1  source of out_data (0 = in0, 1 = in1).
- grant_cnt0  output  16  count of channel-0 transfers, wraps at 0xFFFF to 0.
- grant_cnt1  output  16  count of channel-1 transfers, wraps at 0xFFFF to 0.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_src=0, grant_cnt0/1=0, last_grant=1 (so in0 wins the first contest). in0_ready and in1_ready are 0 while in reset.
- A transfer on a channel occurs on a rising clk edge where that channel's valid and ready are both 1.
- load_ok = !out_valid || out_ready.
  - Combinational; the only combinational path from out_ready to in*_ready.
- Winner selection (combinational):
  - Only one valid: that channel wins.
  - Both valid: the channel != last_grant wins (round robin).
  - Neither valid: no winner.
- inX_ready = load_ok && (winner == X). At most one ready is high per cycle. Ready must not depend on that channel's own valid beyond the winner logic.
- On a transfer from X:
  - out_data <= inX_data, out_src <= X, out_valid <= 1.
  - last_grant <= X, grant_cntX <= grant_cntX + 1, modulo 2^16.
- Output handshake:
  - out_valid && out_ready && no new transfer: out_valid <= 0.
  - Simultaneous drain and load: out_valid stays 1 and the register takes the new data. Sustained one transfer per cycle.
- Latency: input transfer at edge N, data visible on out_data after edge N, consumable at edge N+1.
- Stall: out_valid=1 && out_ready=0 → out_data and out_src held stable, both in*_ready=0, last_grant unchanged.
- Starvation bound: with both channels continuously valid and out_ready=1, grants alternate strictly 0,1,0,1…
- Reset mid-operation: held output data is discarded (out_valid→0 immediately). Counters clear. The arbiter restarts with in0 preferred.
- No X propagation: out_data only updates on a transfer.

Optional Feature:
- Macro MUX16_2_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority; in0 always wins when both are valid. last_grant is not implemented, and in1 can starve. All other behaviour is unchanged.

Test Plan:
- Reset release with in0_valid=1, in0_data=0x1234, out_ready=1 → in0_ready=1 on the first cycle. Next cycle out_valid=1, out_data=0x1234, out_src=0, grant_cnt0=1.
- Both valid, data 0xAAAA/0x5555, out_ready=1 for 6 cycles → out_src sequence 0,1,0,1,0,1 (RR build). Fixed-priority build gives all 0 with in1_ready never 1. Counters 3/3 (RR).
- Output holds 0xBEEF with out_ready=0 for 4 cycles while both inputs are valid → out_data stays 0xBEEF, in0_ready=in1_ready=0, counters unchanged. Then out_ready=1 → drain and new load on the same edge, out_valid stays 1.
- Only in1 valid with in1_data incrementing from 0x0001, out_ready=1 for 5 cycles → out_data 0x0001..0x0005 back-to-back, out_src=1, grant_cnt1=5.
- Preload grant_cnt0 to 0xFFFF via 65535 transfers, then one more in0 transfer → grant_cnt0=0x0000.
- rst_n pulsed low asynchronously mid-cycle with out_valid=1 → out_valid=0 and counters 0 before the next edge. The first contest after release is won by in0.
